// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, sub-block field and defaults for the memory access scheduler
package mem_pkg;
    localparam int ADDR_W           = 11;
    localparam int DATA_W           = 8;
    localparam int SB_HI            = 10;
    localparam int SB_LO            = 7;
    localparam int SB_W             = SB_HI - SB_LO + 1;
    localparam int STARVE_LIMIT_DEF = 3;

    function automatic logic [SB_W-1:0] sub_block(input logic [ADDR_W-1:0] addr);
        return addr[SB_HI:SB_LO];
    endfunction
endpackage

// File: rtl/wr_fifo.sv
// rtl/wr_fifo.sv - in-order write buffer exposing every entry's address for hazard checks
module wr_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [ADDR_W-1:0] entry_addr_o [DEPTH],
    output logic [DEPTH-1:0]  entry_valid_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              do_push, do_pop;

    assign full_o      = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    // Pointers are PTR_W bits wide, so incrementing wraps modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr_q] <= addr_i;
            data_q[wr_ptr_q] <= data_i;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] offset;
        assign offset           = PTR_W'(i) - rd_ptr_q;
        assign entry_valid_o[i] = ({1'b0, offset} < count_q);
        assign entry_addr_o[i]  = addr_q[i];
    end
endmodule

// File: rtl/mem_access_scheduler.sv
// rtl/mem_access_scheduler.sv - read-priority scheduler with buffered writes, RAW stall and starvation forcing
module mem_access_scheduler
    import mem_pkg::*;
#(
    parameter int WBUF_DEPTH   = 4,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic                  full, empty;
    logic [ADDR_W-1:0]     head_addr;
    logic [DATA_W-1:0]     head_data;
    logic [ADDR_W-1:0]     entry_addr [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] entry_valid;

    logic             push, pop, raw_hit, force_wr, rd_issue, conflict;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rvalid_q;

    wr_fifo #(.DEPTH(WBUF_DEPTH)) u_wr_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .addr_i       (wr_addr),
        .data_i       (wr_data),
        .full_o       (full),
        .empty_o      (empty),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .entry_addr_o (entry_addr),
        .entry_valid_o(entry_valid)
    );

    assign wr_ready = !full && !rst;
    assign push     = wr_valid && wr_ready;
    assign force_wr = (starve_q == CNT_W'(STARVE_LIMIT));

    // The write being accepted this cycle counts as buffered, so a same-address read waits behind it.
    always_comb begin
        raw_hit = push && (wr_addr == rd_addr);
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == rd_addr)) raw_hit = 1'b1;
        end
    end

    assign rd_ready = !rst && !force_wr && !raw_hit;
    assign rd_issue = rd_valid && rd_ready;
    assign conflict = rd_issue && !empty && (sub_block(rd_addr) == sub_block(head_addr));
    // A forced cycle holds the read back, so it can never conflict and the head always goes.
    assign pop      = !rst && !empty && !conflict;

    assign mem_ren   = rd_issue;
    assign mem_raddr = rd_issue ? rd_addr : '0;
    assign mem_wen   = pop;
    assign mem_waddr = pop ? head_addr : '0;
    assign mem_din   = pop ? head_data : '0;

    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (conflict) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            rvalid_q <= rd_issue;
        end
    end

    assign rdata_valid = rvalid_q && !rst;
    assign rdata       = rdata_valid ? mem_dout : '0;
endmodule

// File: tb/tb_mem_access_scheduler.sv
// tb/tb_mem_access_scheduler.sv - directed self-checking bench for mem_access_scheduler
module tb_mem_access_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, wr_ready, rd_valid, rd_ready;
    logic [10:0] wr_addr, rd_addr, mem_raddr, mem_waddr;
    logic [7:0]  wr_data, rdata, mem_din, mem_dout;
    logic        rdata_valid, mem_ren, mem_wen;
    logic        rst_next;
    logic [7:0]  mem [2048];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_access_scheduler #(.WBUF_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rdata_valid(rdata_valid),
        .rdata      (rdata),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_din;
        if (mem_ren) mem_dout <= mem[mem_raddr];
    end

    function automatic logic [7:0] init_val(input logic [10:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [10:0] wa, input logic [7:0] wd,
                         input logic rv, input logic [10:0] ra);
        @(negedge clk);
        rst      = rst_next;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_valid = rv;
        rd_addr  = ra;
        #1;
    endtask

    initial begin
        int          lows, low_at, wens, wen_at;
        logic [10:0] rd_a, waddr_seen;

        for (int i = 0; i < 2048; i++) mem[i] = init_val(11'(i));
        mem_dout = 8'h00;
        rst = 1'b1; rst_next = 1'b1;
        wr_valid = 1'b0; rd_valid = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;

        drive(0, 0, 0, 0, 0);
        drive(1, 11'h010, 8'h01, 1, 11'h020);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_mem_ren", mem_ren, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_raddr", mem_raddr, 0);
        check("rst_rdata_valid", rdata_valid, 0);
        check("rst_rdata", rdata, 0);
        rst_next = 1'b0;

        // write then read back through the buffer
        drive(1, 11'h123, 8'hA5, 0, 0);
        check("wb_wr_ready", wr_ready, 1);
        check("wb_wen_c0", mem_wen, 0);
        drive(0, 0, 0, 0, 0);
        check("wb_wen_c1", mem_wen, 1);
        check("wb_waddr", mem_waddr, 11'h123);
        check("wb_din", mem_din, 8'hA5);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 11'h123);
        check("wb_rd_ready", rd_ready, 1);
        check("wb_mem_ren", mem_ren, 1);
        check("wb_raddr", mem_raddr, 11'h123);
        check("wb_rvalid_c0", rdata_valid, 0);
        drive(0, 0, 0, 0, 0);
        check("wb_rvalid_c1", rdata_valid, 1);
        check("wb_rdata", rdata, 8'hA5);
        drive(0, 0, 0, 0, 0);
        check("wb_rvalid_c2", rdata_valid, 0);

        // same sub-block: read wins, write waits
        drive(1, 11'h080, 8'h11, 1, 11'h085);
        check("cf_rd_ready", rd_ready, 1);
        drive(0, 0, 0, 1, 11'h086);
        check("cf_wen_held", mem_wen, 0);
        check("cf_rd_ready2", rd_ready, 1);
        check("cf_rdata_085", rdata, 8'hDF);
        drive(0, 0, 0, 0, 0);
        check("cf_wen_free", mem_wen, 1);
        check("cf_waddr", mem_waddr, 11'h080);
        check("cf_rdata_086", rdata, 8'hDC);

        // different sub-blocks issue together
        drive(1, 11'h200, 8'h22, 0, 0);
        drive(0, 0, 0, 1, 11'h005);
        check("par_ren", mem_ren, 1);
        check("par_wen", mem_wen, 1);
        check("par_waddr", mem_waddr, 11'h200);
        drive(0, 0, 0, 0, 0);

        // starvation forcing
        lows = 0; low_at = -1; wens = 0; wen_at = -1; waddr_seen = '0;
        rd_a = 11'h101;
        drive(1, 11'h105, 8'h77, 1, 11'h100);
        check("st_first_rd", rd_ready, 1);
        for (int c = 1; c <= 8; c++) begin
            drive(0, 0, 0, 1, rd_a);
            if (!rd_ready) begin lows++; low_at = c; end
            if (mem_wen) begin wens++; wen_at = c; waddr_seen = mem_waddr; end
            if (rd_ready) rd_a = rd_a + 11'd1;
        end
        check("st_low_count", lows, 1);
        check("st_low_cycle", low_at, 4);
        check("st_wen_count", wens, 1);
        check("st_wen_cycle", wen_at, 4);
        check("st_waddr", waddr_seen, 11'h105);
        drive(0, 0, 0, 0, 0);

        // fill the buffer while reads keep blocking the head
        for (int c = 0; c < 4; c++) begin
            drive(1, 11'(11'h180 + c), 8'(8'h30 + c), 1, 11'(11'h190 + c));
            check($sformatf("fl_wr_ready_%0d", c), wr_ready, 1);
        end
        drive(1, 11'h184, 8'h34, 1, 11'h194);
        check("fl_full", wr_ready, 0);
        check("fl_force_rd", rd_ready, 0);
        check("fl_force_wen", mem_wen, 1);
        check("fl_force_waddr", mem_waddr, 11'h180);
        drive(1, 11'h184, 8'h34, 0, 0);
        check("fl_5th_accept", wr_ready, 1);
        check("fl_waddr_1", mem_waddr, 11'h181);
        for (int c = 2; c <= 4; c++) begin
            drive(0, 0, 0, 0, 0);
            check($sformatf("fl_waddr_%0d", c), mem_waddr, 11'(11'h180 + c));
        end
        check("fl_din_4", mem_din, 8'h34);

        // same-address write and read in one cycle
        drive(1, 11'h7FF, 8'h3C, 1, 11'h7FF);
        check("raw_wr_ready", wr_ready, 1);
        check("raw_rd_stall0", rd_ready, 0);
        drive(0, 0, 0, 1, 11'h7FF);
        check("raw_rd_stall1", rd_ready, 0);
        check("raw_wen", mem_wen, 1);
        check("raw_waddr", mem_waddr, 11'h7FF);
        drive(0, 0, 0, 1, 11'h7FF);
        check("raw_rd_go", rd_ready, 1);
        drive(0, 0, 0, 0, 0);
        check("raw_rvalid", rdata_valid, 1);
        check("raw_rdata", rdata, 8'h3C);

        // reset with buffered writes and a read in flight
        drive(1, 11'h300, 8'h55, 1, 11'h310);
        drive(1, 11'h301, 8'h66, 1, 11'h311);
        check("rr_wen_blocked", mem_wen, 0);
        rst_next = 1'b1;
        drive(0, 0, 0, 1, 11'h312);
        check("rr_wr_ready", wr_ready, 0);
        check("rr_rd_ready", rd_ready, 0);
        check("rr_mem_ren", mem_ren, 0);
        check("rr_mem_wen", mem_wen, 0);
        check("rr_waddr", mem_waddr, 0);
        check("rr_din", mem_din, 0);
        check("rr_rvalid", rdata_valid, 0);
        check("rr_rdata", rdata, 0);
        rst_next = 1'b0;
        drive(0, 0, 0, 0, 0);
        check("rr_post_wen", mem_wen, 0);
        check("rr_post_rvalid", rdata_valid, 0);
        check("rr_post_wr_ready", wr_ready, 1);
        drive(0, 0, 0, 1, 11'h300);
        check("rr_rd300_ready", rd_ready, 1);
        drive(0, 0, 0, 1, 11'h301);
        check("rr_rd300_data", rdata, 8'h5A);
        drive(0, 0, 0, 0, 0);
        check("rr_rd301_data", rdata, 8'h5B);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_access_scheduler.md
MEM_ACCESS_SCHEDULER -- requirements
Module: mem_access_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter WBUF_DEPTH, default 4, SHALL set the write-buffer entry count (power of two, 2..8).
REQ-003 Parameter STARVE_LIMIT, default 3, SHALL set the consecutive blocked cycles tolerated before a buffered write is forced.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 wr_valid  in  1  write request present.
REQ-007 wr_ready  out  1  write request accepted this cycle when wr_valid is also high.
REQ-008 wr_addr  in  11  write byte address.
REQ-009 wr_data  in  8  write data.
REQ-010 rd_valid  in  1  read request present.
REQ-011 rd_ready  out  1  read request issued this cycle when rd_valid is also high.
REQ-012 rd_addr  in  11  read byte address.
REQ-013 rdata_valid  out  1  rdata holds the result of the read issued in the previous cycle.
REQ-014 rdata  out  8  read result.
REQ-015 mem_ren, mem_wen  out  1 each  read/write enables to the downstream multi-bank memory.
REQ-016 mem_raddr, mem_waddr  out  11 each  addresses to the memory.
REQ-017 mem_din  out  8  write data to the memory; mem_dout  in  8  memory read data, valid one cycle after mem_ren.

Function
REQ-018 Sub-block index SHALL be address bits [10:7]; a "conflict" is an issued read and a pending write with equal sub-block index in the same cycle.
REQ-019 Accepted writes SHALL be queued in order in a WBUF_DEPTH-entry FIFO; wr_ready = not full and not rst; no push when full, even if a pop occurs that cycle.
REQ-020 rd_ready SHALL be high unless rst, a force cycle (REQ-023), or rd_addr equals the full 11-bit address of any valid buffer entry (RAW stall).
REQ-021 Issued read: mem_ren=1 and mem_raddr=rd_addr combinationally in the same cycle; otherwise mem_ren=0, mem_raddr=0.
REQ-022 FIFO head SHALL issue (mem_wen=1, mem_waddr/mem_din = head entry, pop) when the buffer is non-empty and there is no conflict with an issued read; otherwise mem_wen=0, mem_waddr=0, mem_din=0.
REQ-023 Starvation counter SHALL increment each cycle the non-empty head is blocked by conflict, clear on a head issue or when empty, and on reaching STARVE_LIMIT force the next cycle: rd_ready=0, head issues, counter clears.
REQ-024 Reads and writes to different sub-blocks SHALL issue in the same cycle.
REQ-025 rdata_valid SHALL be a one-cycle-delayed copy of (rd_valid and rd_ready); rdata = mem_dout while rdata_valid is high, else 0.
REQ-026 Read latency SHALL be exactly one cycle from issue to rdata_valid; back-to-back reads SHALL sustain one result per cycle.
REQ-027 A write and a read to the same address presented in the same cycle SHALL be handled as write first: accepted write pushes, read stalls until drained (RAW comparison includes the incoming accepted entry).
REQ-028 FIFO pointers SHALL wrap modulo WBUF_DEPTH; occupancy counter SHALL be clog2(WBUF_DEPTH)+1 bits.

Reset
REQ-029 While rst is high: wr_ready=0, rd_ready=0, mem_ren=0, mem_wen=0, all memory address/data outputs 0, rdata_valid=0, rdata=0.
REQ-030 On the clock edge with rst high: FIFO empty, pointers 0, starvation counter 0, rdata_valid register 0; buffered writes are discarded and an in-flight read result is dropped.

Structure
REQ-031 A shared package mem_pkg SHALL hold ADDR_W=11, DATA_W=8, the sub-block field bounds [10:7], and the STARVE_LIMIT default.
REQ-032 The write buffer SHALL be a separate sub-module wr_fifo with push/pop/full/empty and per-entry address visibility for the RAW compare.

Verification
REQ-033 Write 0x123<-0xA5, then 2 idle cycles, read 0x123 -> mem_wen in cycle 1 with waddr 0x123; rdata_valid one cycle after read issue, rdata=0xA5.
REQ-034 Same cycle: write 0x080<-0x11, read 0x085 (both sub-block 1) -> read issues, write held; write issues next cycle when no read is present.
REQ-035 Continuous reads to 0x100..0x1FF with write 0x105 pending, STARVE_LIMIT=3 -> rd_ready low exactly once, on the 4th cycle; write issues that cycle.
REQ-036 Five writes with no pop possible (reads conflicting), WBUF_DEPTH=4 -> wr_ready low after the 4th accept; 5th accepted only after a pop.
REQ-037 Same cycle: write 0x7FF<-0x3C, read 0x7FF -> rd_ready=0 until the write drains; then rdata=0x3C.
REQ-038 rst asserted with 2 writes buffered and a read in flight -> next cycle all outputs 0, rdata_valid=0; post-reset read of those addresses returns the pre-write memory contents.
